// File: rtl/dm_cache_refill.sv
// dm_cache_refill: direct-mapped, read-only cache with a built-in line refill engine.
// A CPU word read is looked up one cycle after it is accepted. Hits answer from the line
// array. Misses fetch the whole line from memory, install it, then answer with the
// requested word. Hit and miss counters saturate, and a flush in IDLE invalidates every line.
module dm_cache_refill #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 8,
  parameter int CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         resp_valid,
  output logic [WORD_W-1:0]            resp_data,
  output logic                         resp_hit,
  input  logic                         flush,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDR_W-1:0]            mem_req_addr,
  input  logic                         mem_rvalid,
  input  logic [WORD_W*LINE_WORDS-1:0] mem_rdata,
  output logic [CNT_W-1:0]             hit_cnt,
  output logic [CNT_W-1:0]             miss_cnt
);

  localparam int OFFS_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFFS_W - 2;
  localparam int LINE_W = WORD_W * LINE_WORDS;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LOOKUP      = 3'd1;
  localparam logic [2:0] S_RESP_OUT    = 3'd2;
  localparam logic [2:0] S_REFILL_REQ  = 3'd3;
  localparam logic [2:0] S_REFILL_WAIT = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-3:0] addr_q;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [LINE_W-1:0] data_arr [LINES];

  logic [OFFS_W-1:0] cur_off;
  logic [IDX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]  cur_tag;
  logic [LINE_W-1:0] cur_line;
  logic              lookup_hit;
  logic              fill_now;
  logic              unused_addr_bits;

  // Byte-lane bits never select anything; the cache works on word addresses only.
  assign unused_addr_bits = ^req_addr[1:0];

  // Field decode of the latched word address and tag compare against the indexed line.
  always_comb begin
    cur_off    = addr_q[OFFS_W-1:0];
    cur_idx    = addr_q[OFFS_W +: IDX_W];
    cur_tag    = addr_q[ADDR_W-3 -: TAG_W];
    cur_line   = data_arr[cur_idx];
    lookup_hit = valid_q[cur_idx] && (tag_arr[cur_idx] == cur_tag);
    fill_now   = (state == S_REFILL_WAIT) && mem_rvalid;
    req_ready  = (state == S_IDLE) && !flush;
    resp_valid = (state == S_RESP_OUT);
  end

  // Main controller: request acceptance, lookup, refill handshake, response and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      valid_q       <= '0;
      resp_data     <= '0;
      resp_hit      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (req_valid) begin
            addr_q <= req_addr[ADDR_W-1:2];
            state  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (lookup_hit) begin
            resp_data <= cur_line[cur_off*WORD_W +: WORD_W];
            resp_hit  <= 1'b1;
            if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_ONE;
            state     <= S_RESP_OUT;
          end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_ONE;
            mem_req_addr  <= {cur_tag, cur_idx, {(OFFS_W+2){1'b0}}};
            mem_req_valid <= 1'b1;
            state         <= S_REFILL_REQ;
          end
        end
        S_REFILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_REFILL_WAIT;
          end
        end
        S_REFILL_WAIT: begin
          if (mem_rvalid) begin
            valid_q[cur_idx] <= 1'b1;
            resp_data        <= mem_rdata[cur_off*WORD_W +: WORD_W];
            resp_hit         <= 1'b0;
            state            <= S_RESP_OUT;
          end
        end
        S_RESP_OUT: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Tag and data storage; written only when a refill line arrives, never reset.
  always_ff @(posedge clk) begin
    if (!rst && fill_now) begin
      tag_arr[cur_idx]  <= cur_tag;
      data_arr[cur_idx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dm_cache_refill.sv
// tb_dm_cache_refill: directed self-checking bench for dm_cache_refill with
// LINES=8 and LINE_WORDS=4. A small memory responder inside doRead serves refills.
module tb_dm_cache_refill;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         resp_valid;
  logic [31:0]  resp_data;
  logic         resp_hit;
  logic         flush;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_rvalid;
  logic [127:0] mem_rdata;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  localparam logic [127:0] LINE_A = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
  localparam logic [127:0] LINE_B = 128'h77770003_66660002_55550001_44440000;

  dm_cache_refill #(
    .ADDR_W(32), .WORD_W(32), .LINE_WORDS(4), .LINES(8), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
    .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the design hangs somewhere unbounded.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] obs, input logic [127:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one read request; returns 1 ns after the accept edge.
  task automatic applyStimulus(input logic [31:0] addr, input string name);
    int waited = 0;
    while (!req_ready && waited < 50) begin
      tick();
      waited++;
    end
    checkOutput({name, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFC;
  endtask

  // Full read transaction with a memory responder that stalls mem_req_ready for 'stall' cycles.
  task automatic doRead(input logic [31:0] addr, input logic exp_hit, input logic [31:0] exp_data,
                        input logic [31:0] exp_maddr, input logic [127:0] line, input int stall,
                        input string name);
    int cyc = 0;
    int fetches = 0;
    int stall_left = stall;
    bit got = 0;
    bit seen = 0;
    bit stable = 1;
    bit rv_next = 0;
    logic [31:0] held = '0;
    applyStimulus(addr, name);
    checkOutput({name, "_lookup_rv"}, resp_valid, 1'b0);
    while (!got && cyc < 60) begin
      mem_req_ready = 1'b0;
      mem_rvalid    = 1'b0;
      mem_rdata     = '0;
      if (rv_next) begin
        mem_rvalid = 1'b1;
        mem_rdata  = line;
        rv_next    = 0;
      end
      if (mem_req_valid) begin
        if (!seen) begin
          held = mem_req_addr;
          seen = 1;
          checkOutput({name, "_maddr"}, mem_req_addr, exp_maddr);
        end else if (mem_req_addr !== held) begin
          stable = 0;
        end
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          mem_req_ready = 1'b1;
          fetches++;
          rv_next = 1;
        end
      end
      tick();
      cyc++;
      if (resp_valid) got = 1;
    end
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    checkOutput({name, "_resp"}, got, 1'b1);
    if (exp_hit) checkOutput({name, "_latency"}, cyc, 1);
    if (seen) checkOutput({name, "_req_stable"}, stable, 1'b1);
    checkOutput({name, "_fetches"}, fetches, exp_hit ? 0 : 1);
    checkOutput({name, "_data"}, resp_data, exp_data);
    checkOutput({name, "_hit"}, resp_hit, exp_hit);
    tick();
    checkOutput({name, "_pulse_end"}, resp_valid, 1'b0);
    checkOutput({name, "_data_hold"}, resp_data, exp_data);
  endtask

  // Compare every output against its reset value.
  task automatic checkResetState(input string name);
    checkOutput({name, "_req_ready"}, req_ready, 1'b1);
    checkOutput({name, "_resp_valid"}, resp_valid, 1'b0);
    checkOutput({name, "_resp_data"}, resp_data, 32'h0);
    checkOutput({name, "_resp_hit"}, resp_hit, 1'b0);
    checkOutput({name, "_mem_req_valid"}, mem_req_valid, 1'b0);
    checkOutput({name, "_mem_req_addr"}, mem_req_addr, 32'h0);
    checkOutput({name, "_hit_cnt"}, hit_cnt, 32'h0);
    checkOutput({name, "_miss_cnt"}, miss_cnt, 32'h0);
  endtask

  // Directed test sequence.
  initial begin
    int waited;
    bit any_resp;
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    flush = 1'b0;
    mem_req_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    checkResetState("reset");

    // Cold miss, then hits on the same line including both word-offset extremes.
    doRead(32'h0000_1234, 1'b0, 32'hBBBB0001, 32'h0000_1230, LINE_A, 0, "cold_miss");
    checkOutput("cold_miss_cnt", miss_cnt, 32'd1);
    doRead(32'h0000_1238, 1'b1, 32'hCCCC0002, 32'h0, LINE_A, 0, "hit_w2");
    checkOutput("hit_w2_cnt", hit_cnt, 32'd1);
    doRead(32'h0000_123C, 1'b1, 32'hDDDD0003, 32'h0, LINE_A, 0, "hit_w3");
    doRead(32'h0000_1230, 1'b1, 32'hAAAA0000, 32'h0, LINE_A, 0, "hit_w0");
    checkOutput("hits_cnt", hit_cnt, 32'd3);

    // Conflict on index 3: a different tag evicts the line, so the original misses again.
    doRead(32'h0000_1A34, 1'b0, 32'h55550001, 32'h0000_1A30, LINE_B, 0, "conflict_a");
    doRead(32'h0000_1234, 1'b0, 32'hBBBB0001, 32'h0000_1230, LINE_A, 0, "conflict_b");
    checkOutput("conflict_miss_cnt", miss_cnt, 32'd3);

    // Flush together with a request: the request is refused and the line is invalidated.
    flush = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h0000_1238;
    #1;
    checkOutput("flush_req_ready", req_ready, 1'b0);
    tick();
    flush = 1'b0;
    req_valid = 1'b0;
    any_resp = 0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid || mem_req_valid) any_resp = 1;
      tick();
    end
    checkOutput("flush_not_accepted", any_resp, 1'b0);
    checkOutput("flush_idle", req_ready, 1'b1);
    doRead(32'h0000_1238, 1'b0, 32'hCCCC0002, 32'h0000_1230, LINE_A, 0, "after_flush");
    checkOutput("flush_cnts", {hit_cnt, miss_cnt}, {32'd3, 32'd4});

    // Memory backpressure for five cycles: request held stable and issued once.
    doRead(32'h0000_1A38, 1'b0, 32'h66660002, 32'h0000_1A30, LINE_B, 5, "backpressure");
    checkOutput("bp_miss_cnt", miss_cnt, 32'd5);
    doRead(32'h0000_1A3C, 1'b1, 32'h77770003, 32'h0, LINE_B, 0, "bp_hit");

    // Reset while waiting for the refill line; the late line must be ignored.
    applyStimulus(32'h0000_2004, "rst_mid");
    waited = 0;
    while (!mem_req_valid && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("rst_mid_req", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = LINE_A;
    any_resp = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (resp_valid) any_resp = 1;
      mem_rvalid = 1'b0;
    end
    checkOutput("rst_mid_no_resp", any_resp, 1'b0);
    checkResetState("rst_mid");
    doRead(32'h0000_2004, 1'b0, 32'hBBBB0001, 32'h0000_2000, LINE_A, 0, "rst_reread");
    checkOutput("rst_reread_cnts", {hit_cnt, miss_cnt}, {32'd0, 32'd1});

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
